rggen_register_bus_initiator: RTL
=================================

// Module: rggen_register_bus_initiator
// PURPOSE
//  Host-side initiator for the register bus. Accepts one host request at a time
//  (valid/ready), drives the register bus request (valid/access/address/data/strobe)
//  and holds it until the addressed register answers. Returns read data and status
//  on a response valid/ready channel. Sits between a bus protocol front-end and the
//  OR-reduced response of all register instances.
// PARAMETERS
//  ADDRESS_WIDTH   8      register bus address width (byte address)
//  BUS_WIDTH       32     data width, multiple of 8
//  TIMEOUT_CYCLES  0      cycles in BUSY before forced error; 0 = timeout disabled
//  ERROR_STATUS    2'b10  status returned on no-hit or timeout
// PORTS
//  i_clk                  in   1              clock
//  i_rst                  in   1              reset, asynchronous, active-high
//  i_host_valid           in   1              host request valid
//  o_host_ready           out  1              host request accepted this cycle
//  i_host_access          in   2              [1]=1 read/write, [0]=1 write (2'b10 rd, 2'b11 wr, 2'b01 posted wr)
//  i_host_address         in   ADDRESS_WIDTH  byte address; low log2(BUS_WIDTH/8) bits ignored
//  i_host_write_data      in   BUS_WIDTH      write data
//  i_host_strobe          in   BUS_WIDTH/8    byte enables (forced all-ones on read)
//  o_resp_valid           out  1              response valid
//  i_resp_ready           in   1              response accepted
//  o_resp_status          out  2              2'b00 OK, else register status or ERROR_STATUS
//  o_resp_read_data       out  BUS_WIDTH      read data (zero on write and on error)
//  o_register_valid       out  1              register bus request valid
//  o_register_access      out  2              registered copy of i_host_access
//  o_register_address     out  ADDRESS_WIDTH  word-aligned address
//  o_register_write_data  out  BUS_WIDTH      registered write data
//  o_register_strobe      out  BUS_WIDTH/8    registered strobe
//  i_register_active      in   1              OR of all register active (address hit)
//  i_register_ready       in   1              OR of all register ready
//  i_register_status      in   2              OR of all register status
//  i_register_read_data   in   BUS_WIDTH      OR of all register read data
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (o_host_ready=0, o_resp_valid=0, request regs 0).
//  FSM IDLE -> BUSY -> RESPONSE -> IDLE.
//  - IDLE: o_host_ready=1. i_host_valid=1 captures access/address/data/strobe,
//    aligns address, clears timeout counter, goes to BUSY. o_register_valid=1 from
//    the next cycle.
//  - BUSY: o_register_valid=1; request regs stable. Per cycle, first match wins:
//    i_register_active && i_register_ready: capture status and read data
//      (read data zeroed unless access is a read), -> RESPONSE;
//    !i_register_active: status=ERROR_STATUS, data=0, -> RESPONSE (no-hit);
//    TIMEOUT_CYCLES!=0 && counter==TIMEOUT_CYCLES-1: status=ERROR_STATUS, data=0,
//      -> RESPONSE;
//    else counter++ (saturates; no wrap).
//    o_register_valid drops in the cycle after completion.
//  - RESPONSE: o_resp_valid=1, data/status held until i_resp_ready=1, then IDLE.
//    o_host_ready=0 in BUSY and RESPONSE; no overlap/pipelining.
//  - Best-case latency: host accept at cycle N, register valid N+1, ready at N+1,
//    response valid N+2. Zero-cycle-ready registers still take 3 cycles/transfer.
//  - Ready and active both low in the same BUSY cycle counts as no-hit (error).
//  - i_rst mid-transfer: abort immediately, all outputs 0, no response produced.
// TESTING
//  1 Read 0x04, register active, ready in 1st BUSY cycle with data 0xDEADBEEF ->
//    resp status 00, data 0xDEADBEEF two cycles after host accept.
//  2 Write 0x08 data 0x12345678 strobe 4'b0011, ready after 3 wait cycles ->
//    register bus request stable 4 cycles, resp status 00, data 0.
//  3 Read 0x40, i_register_active=0 -> resp status 2'b10, data 0, one BUSY cycle.
//  4 TIMEOUT_CYCLES=4, active=1, ready never -> error response after exactly 4 BUSY
//    cycles; with TIMEOUT_CYCLES=0 and ready after 100 cycles -> OK response.
//  5 Hold i_resp_ready=0 for 5 cycles -> resp held stable, o_host_ready=0,
//    new i_host_valid ignored until accepted.
//  6 Assert i_rst in BUSY -> all outputs 0 next edge, no response; then a new read
//    completes normally.

Source files
------------

// File: rtl/rggen_register_bus_initiator.sv
// Host-side register bus initiator: takes one host request at a time, holds it on
// the register bus until a register answers (or misses / times out), then returns a response.
module rggen_register_bus_initiator #(
  parameter int         ADDRESS_WIDTH  = 8,
  parameter int         BUS_WIDTH      = 32,
  parameter int         TIMEOUT_CYCLES = 0,
  parameter logic [1:0] ERROR_STATUS   = 2'b10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_host_valid,
  output logic                     o_host_ready,
  input  logic [1:0]               i_host_access,
  input  logic [ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [BUS_WIDTH-1:0]     i_host_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_host_strobe,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [1:0]               o_resp_status,
  output logic [BUS_WIDTH-1:0]     o_resp_read_data,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
  input  logic                     i_register_active,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int LSB    = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPONSE
  } state_e;

  state_e                   state_q;
  logic                     host_ready_q;
  logic                     resp_valid_q;
  logic [1:0]               resp_status_q;
  logic [BUS_WIDTH-1:0]     resp_read_data_q;
  logic                     register_valid_q;
  logic [1:0]               register_access_q;
  logic [ADDRESS_WIDTH-1:0] register_address_q;
  logic [BUS_WIDTH-1:0]     register_write_data_q;
  logic [STRB_W-1:0]        register_strobe_q;
  logic [CNT_W-1:0]         count_q;
  logic                     timeout_hit;
  logic                     is_read;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == CNT_LAST);
  assign is_read     = ~register_access_q[0];

  // NOTE: every state bit uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the async reset clears every register, aborting any transfer in flight.
      state_q               <= IDLE;
      host_ready_q          <= 1'b0;
      resp_valid_q          <= 1'b0;
      resp_status_q         <= '0;
      resp_read_data_q      <= '0;
      register_valid_q      <= 1'b0;
      register_access_q     <= '0;
      register_address_q    <= '0;
      register_write_data_q <= '0;
      register_strobe_q     <= '0;
      count_q               <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          host_ready_q <= 1'b1;
          if (host_ready_q && i_host_valid) begin
            host_ready_q          <= 1'b0;
            register_valid_q      <= 1'b1;
            register_access_q     <= i_host_access;
            register_address_q    <= i_host_address & ADDR_MASK;
            register_write_data_q <= i_host_write_data;
            register_strobe_q     <= i_host_access[0] ? i_host_strobe : '1;
            count_q               <= '0;
            state_q               <= BUSY;
          end
        end
        BUSY: begin
          if (i_register_active && i_register_ready) begin
            register_valid_q <= 1'b0;
            resp_valid_q     <= 1'b1;
            resp_status_q    <= i_register_status;
            resp_read_data_q <= is_read ? i_register_read_data : '0;
            state_q          <= RESPONSE;
          end else if (!i_register_active || timeout_hit) begin
            register_valid_q <= 1'b0;
            resp_valid_q     <= 1'b1;
            resp_status_q    <= ERROR_STATUS;
            resp_read_data_q <= '0;
            state_q          <= RESPONSE;
          end else if (count_q != CNT_MAX) begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        RESPONSE: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            host_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_host_ready          = host_ready_q;
  assign o_resp_valid          = resp_valid_q;
  assign o_resp_status         = resp_status_q;
  assign o_resp_read_data      = resp_read_data_q;
  assign o_register_valid      = register_valid_q;
  assign o_register_access     = register_access_q;
  assign o_register_address    = register_address_q;
  assign o_register_write_data = register_write_data_q;
  assign o_register_strobe     = register_strobe_q;

endmodule
